// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input and instruction-memory write port of the loader
interface instr_mem_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic wr_en;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  modport master(output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
  modport slave(input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a framed, XOR-checksummed byte stream into the 256x32 instruction memory
module instr_mem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'd0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic reset,
  input logic start,
  instr_mem_loader_if.slave bus,
  output logic busy,
  output logic cpu_hold,
  output logic done,
  output logic error,
  output logic [8:0] words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [8:0] words_q, words_d;
  logic [8:0] n_q, n_d;
  logic [7:0] chk_q, chk_d;
  logic [1:0] bidx_q, bidx_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic done_q, done_d;
  logic error_q, error_d;
  logic xfer;
  assign bus.in_ready = state_q inside {S_COUNT, S_DATA, S_CHECK};
  assign bus.wr_en = state_q == S_WRITE;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy = state_q inside {S_COUNT, S_DATA, S_WRITE, S_CHECK};
  assign cpu_hold = busy;
  assign done = done_q;
  assign error = error_q;
  assign words_loaded = words_q;
  assign xfer = bus.in_valid & bus.in_ready;
  assign tmo_inc = tmo_q + TW'(1);
  always_comb begin
    state_d = state_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    words_d = words_q;
    n_d = n_q;
    chk_d = chk_q;
    bidx_d = bidx_q;
    tmo_d = tmo_q;
    done_d = done_q;
    error_d = error_q;
    case (state_q)
      S_COUNT: if (xfer) begin
        n_d = {bus.in_data == 8'd0, bus.in_data};
        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        wr_data_d = {wr_data_q[23:0], bus.in_data};
        chk_d = chk_q ^ bus.in_data;
        bidx_d = bidx_q + 2'd1;
        state_d = bidx_q == 2'd3 ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        words_d = words_q + 9'd1;
        wr_addr_d = wr_addr_q + 8'd1;
        state_d = words_d == n_q ? S_CHECK : S_DATA;
      end
      S_CHECK: if (xfer) begin
        done_d = bus.in_data == chk_q;
        error_d = bus.in_data != chk_q;
        state_d = bus.in_data == chk_q ? S_DONE : S_ERR;
      end
      default: if (start) begin
        state_d = S_COUNT;
        done_d = 1'b0;
        error_d = 1'b0;
        words_d = '0;
        chk_d = '0;
        bidx_d = '0;
        tmo_d = '0;
        wr_addr_d = BASE_ADDR;
      end
    endcase
    if (bus.in_ready) begin
      tmo_d = xfer ? '0 : tmo_inc;
      if (!xfer && tmo_inc == TW'(TIMEOUT_CYCLES)) begin
        state_d = S_ERR;
        error_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_data_q <= '0;
      wr_addr_q <= BASE_ADDR;
      words_q <= '0;
      n_q <= '0;
      chk_q <= '0;
      bidx_q <= '0;
      tmo_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      words_q <= words_d;
      n_q <= n_d;
      chk_q <= chk_d;
      bidx_q <= bidx_d;
      tmo_q <= tmo_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed frames against two loader instances (base 0, and base 254 with short timeout)
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, hold_a, done_a, err_a, busy_b, hold_b, done_b, err_b;
  logic [8:0] words_a, words_b;
  int errs = 0;
  int checks = 0;
  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [7:0] f1[10] = '{8'h02, 8'h02, 8'h32, 8'h80, 8'h20, 8'h22, 8'h30, 8'h00, 8'h03, 8'h81};
  logic [7:0] fb[14] = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
                         8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h26};
  instr_mem_loader_if ia();
  instr_mem_loader_if ib();
  instr_mem_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(ia), .busy(busy_a), .cpu_hold(hold_a),
    .done(done_a), .error(err_a), .words_loaded(words_a)
  );
  instr_mem_loader #(.BASE_ADDR(8'd254), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(ib), .busy(busy_b), .cpu_hold(hold_b),
    .done(done_b), .error(err_b), .words_loaded(words_b)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ia.wr_en) qa.push_back({ia.wr_addr, ia.wr_data});
    if (ib.wr_en) qb.push_back({ib.wr_addr, ib.wr_data});
  end
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input bit sel, input logic [7:0] b);
    int t = 0;
    if (sel) begin ib.in_data = b; ib.in_valid = 1'b1; end
    else begin ia.in_data = b; ia.in_valid = 1'b1; end
    while (!(sel ? ib.in_ready : ia.in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_wait", 40'(sel ? ib.in_ready : ia.in_ready), 1);
    @(posedge clk);
    #1;
    if (sel) ib.in_valid = 1'b0;
    else ia.in_valid = 1'b0;
  endtask
  task automatic pulse(input bit sel);
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask
  task automatic pop_a(input string tag, input logic [39:0] exp);
    check(tag, qa.size() > 0 ? qa.pop_front() : 40'hxx_xxxxxxxx, exp);
  endtask
  task automatic pop_b(input string tag, input logic [39:0] exp);
    check(tag, qb.size() > 0 ? qb.pop_front() : 40'hxx_xxxxxxxx, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
  initial begin
    ia.in_data = '0; ia.in_valid = 1'b0;
    ib.in_data = '0; ib.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_ready", 40'(ia.in_ready), 0);
    check("rst_wr_en", 40'(ia.wr_en), 0);
    check("rst_busy", 40'(busy_a), 0);
    check("rst_hold", 40'(hold_a), 0);
    check("rst_done", 40'(done_a), 0);
    check("rst_error", 40'(err_a), 0);
    check("rst_addr", 40'(ia.wr_addr), 0);
    check("rst_data", 40'(ia.wr_data), 0);
    check("rst_words", 40'(words_a), 0);
    check("rst_addr_b", 40'(ib.wr_addr), 254);
    pulse(0);
    check("s1_busy", 40'(busy_a), 1);
    check("s1_hold", 40'(hold_a), 1);
    check("s1_ready", 40'(ia.in_ready), 1);
    for (int i = 0; i < 5; i++) send(0, f1[i]);
    check("s1_lat_wr_en", 40'(ia.wr_en), 1);
    check("s1_lat_addr", 40'(ia.wr_addr), 0);
    check("s1_lat_data", 40'(ia.wr_data), 'h02328020);
    check("s1_lat_ready", 40'(ia.in_ready), 0);
    for (int i = 5; i < 7; i++) send(0, f1[i]);
    pulse(0);
    check("s1_start_busy", 40'(busy_a), 1);
    check("s1_start_words", 40'(words_a), 1);
    for (int i = 7; i < 10; i++) send(0, f1[i]);
    check("s1_done", 40'(done_a), 1);
    check("s1_error", 40'(err_a), 0);
    check("s1_busy_end", 40'(busy_a), 0);
    check("s1_hold_end", 40'(hold_a), 0);
    check("s1_words", 40'(words_a), 2);
    check("s1_nwrites", 40'(qa.size()), 2);
    pop_a("s1_w0", {8'h00, 32'h02328020});
    pop_a("s1_w1", {8'h01, 32'h22300003});
    pulse(0);
    check("s2_clear_done", 40'(done_a), 0);
    for (int i = 0; i < 9; i++) send(0, f1[i]);
    send(0, 8'h7E);
    check("s2_error", 40'(err_a), 1);
    check("s2_done", 40'(done_a), 0);
    check("s2_busy", 40'(busy_a), 0);
    check("s2_words", 40'(words_a), 2);
    check("s2_nwrites", 40'(qa.size()), 2);
    pop_a("s2_w0", {8'h00, 32'h02328020});
    pop_a("s2_w1", {8'h01, 32'h22300003});
    pulse(1);
    for (int i = 0; i < 14; i++) send(1, fb[i]);
    check("wrap_done", 40'(done_b), 1);
    check("wrap_error", 40'(err_b), 0);
    check("wrap_words", 40'(words_b), 3);
    check("wrap_nwrites", 40'(qb.size()), 3);
    pop_b("wrap_w0", {8'hFE, 32'hDEADBEEF});
    pop_b("wrap_w1", {8'hFF, 32'h01020304});
    pop_b("wrap_w2", {8'h00, 32'hA5A5A5A5});
    pulse(1);
    send(1, 8'h01);
    send(1, 8'hAA);
    send(1, 8'hBB);
    repeat (7) @(posedge clk);
    #1;
    check("tmo_early_err", 40'(err_b), 0);
    check("tmo_early_busy", 40'(busy_b), 1);
    @(posedge clk);
    #1;
    check("tmo_err", 40'(err_b), 1);
    check("tmo_busy", 40'(busy_b), 0);
    check("tmo_done", 40'(done_b), 0);
    check("tmo_words", 40'(words_b), 0);
    check("tmo_nwrites", 40'(qb.size()), 0);
    pulse(0);
    send(0, 8'h01);
    send(0, 8'h12);
    send(0, 8'h34);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_ready", 40'(ia.in_ready), 0);
    check("mid_rst_busy", 40'(busy_a), 0);
    check("mid_rst_hold", 40'(hold_a), 0);
    check("mid_rst_wr_en", 40'(ia.wr_en), 0);
    check("mid_rst_words", 40'(words_a), 0);
    check("mid_rst_data", 40'(ia.wr_data), 0);
    check("mid_rst_addr", 40'(ia.wr_addr), 0);
    check("mid_rst_err_b", 40'(err_b), 0);
    check("mid_rst_addr_b", 40'(ib.wr_addr), 254);
    check("mid_rst_nwrites", 40'(qa.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
